// File: rtl/serial_adder.sv
// serial_adder: bit-serial adder, one result bit per clock through a single full adder; Done follows WIDTH RUN edges.
// Optional Overflow output is present only when SERIAL_ADDER_OVF_EN is defined.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             Start,
  input  logic [WIDTH-1:0] In_A,
  input  logic [WIDTH-1:0] In_B,
  input  logic             Carry_in,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry_out
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             Overflow
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             carry_q;
  logic [CW-1:0]    cnt;
  logic             fa_s;
  logic             fa_co;
  logic             last_bit;

  full_adder u_full_adder (
    .a  (a_sh[0]),
    .b  (b_sh[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign Busy     = (state == RUN);
  assign Done     = (state == DONE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      Sum       <= '0;
      Carry_out <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      Overflow  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            a_sh    <= In_A;
            b_sh    <= In_B;
            carry_q <= Carry_in;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          // New bit enters at the MSB so the result is LSB-aligned after WIDTH shifts.
          Sum     <= (Sum >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
          a_sh    <= a_sh >> 1;
          b_sh    <= b_sh >> 1;
          carry_q <= fa_co;
          cnt     <= cnt + 1'b1;
          if (last_bit) begin
            Carry_out <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
            // carry_q holds the carry into the MSB during its edge.
            Overflow  <= carry_q ^ fa_co;
`endif
            state     <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH 1, 8 and 32.
module tb_serial_adder;

  logic        clk;
  logic        rst;
  logic        start1, start8, start32;
  logic [31:0] a_in, b_in;
  logic        cin;
  logic        busy1, busy8, busy32;
  logic        done1, done8, done32;
  logic [0:0]  sum1;
  logic [7:0]  sum8;
  logic [31:0] sum32;
  logic        cout1, cout8, cout32;
`ifdef SERIAL_ADDER_OVF_EN
  logic        ovf1, ovf8, ovf32;
`endif

  int n_vec = 0;
  int n_err = 0;

  serial_adder #(.WIDTH(1)) u_w1 (
    .clk_i(clk), .rst_i(rst), .Start(start1), .In_A(a_in[0:0]), .In_B(b_in[0:0]),
    .Carry_in(cin), .Busy(busy1), .Done(done1), .Sum(sum1), .Carry_out(cout1)
`ifdef SERIAL_ADDER_OVF_EN
    , .Overflow(ovf1)
`endif
  );

  serial_adder #(.WIDTH(8)) u_w8 (
    .clk_i(clk), .rst_i(rst), .Start(start8), .In_A(a_in[7:0]), .In_B(b_in[7:0]),
    .Carry_in(cin), .Busy(busy8), .Done(done8), .Sum(sum8), .Carry_out(cout8)
`ifdef SERIAL_ADDER_OVF_EN
    , .Overflow(ovf8)
`endif
  );

  serial_adder #(.WIDTH(32)) u_w32 (
    .clk_i(clk), .rst_i(rst), .Start(start32), .In_A(a_in), .In_B(b_in),
    .Carry_in(cin), .Busy(busy32), .Done(done32), .Sum(sum32), .Carry_out(cout32)
`ifdef SERIAL_ADDER_OVF_EN
    , .Overflow(ovf32)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    case (w)
      1:       start1  = v;
      8:       start8  = v;
      default: start32 = v;
    endcase
  endtask

  function automatic logic get_done(input int w);
    case (w)
      1:       return done1;
      8:       return done8;
      default: return done32;
    endcase
  endfunction

  function automatic logic [31:0] get_sum(input int w);
    case (w)
      1:       return {31'd0, sum1};
      8:       return {24'd0, sum8};
      default: return sum32;
    endcase
  endfunction

  function automatic logic get_cout(input int w);
    case (w)
      1:       return cout1;
      8:       return cout8;
      default: return cout32;
    endcase
  endfunction

`ifdef SERIAL_ADDER_OVF_EN
  function automatic logic get_ovf(input int w);
    case (w)
      1:       return ovf1;
      8:       return ovf8;
      default: return ovf32;
    endcase
  endfunction
`endif

  // One full operation on the width-w instance; entered and left with that instance in IDLE.
  task automatic run_op(input int w, input logic [31:0] a, input logic [31:0] b, input logic ci);
    logic [63:0] mask, lo, full, exp_sum, exp_co, cmsb;
    int          n;
    logic        seen;
    mask    = (64'd1 << w) - 64'd1;
    lo      = mask >> 1;
    full    = ({32'd0, a} & mask) + ({32'd0, b} & mask) + {63'd0, ci};
    exp_sum = full & mask;
    exp_co  = (full >> w) & 64'd1;
    cmsb    = ((({32'd0, a} & lo) + ({32'd0, b} & lo) + {63'd0, ci}) >> (w - 1)) & 64'd1;
    a_in = a; b_in = b; cin = ci;
    set_start(w, 1'b1);
    @(posedge clk); #1;
    set_start(w, 1'b0);
    a_in = ~a; b_in = ~b; cin = ~ci;
    n = 0;
    seen = 1'b0;
    while (n < 64 && !seen) begin
      @(posedge clk); #1;
      n++;
      seen = get_done(w);
    end
    chk($sformatf("latency_w%0d", w), 64'(n), 64'(w));
    chk($sformatf("sum_w%0d_%0h_%0h_%0d", w, a, b, ci), 64'(get_sum(w)), exp_sum);
    chk($sformatf("cout_w%0d_%0h_%0h_%0d", w, a, b, ci), 64'(get_cout(w)), exp_co);
`ifdef SERIAL_ADDER_OVF_EN
    chk($sformatf("ovf_w%0d_%0h_%0h_%0d", w, a, b, ci), 64'(get_ovf(w)), cmsb ^ exp_co);
`endif
    @(posedge clk); #1;
    chk($sformatf("done_pulse_w%0d", w), 64'(get_done(w)), 64'd0);
    chk($sformatf("sum_hold_w%0d", w), 64'(get_sum(w)), exp_sum);
  endtask

  initial begin
    int   ndone, e, first_e, second_e;
    logic [7:0] s_at_done;
    logic       c_at_done;

    rst = 1'b1;
    start1 = 1'b0; start8 = 1'b0; start32 = 1'b0;
    a_in = '0; b_in = '0; cin = 1'b0;
    #2;
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_done", 64'(done8), 64'd0);
    chk("rst_sum", 64'(sum8), 64'd0);
    chk("rst_cout", 64'(cout8), 64'd0);
    #10 rst = 1'b0;

    // Accepted on the first edge after reset release.
    run_op(8, 32'hFF, 32'h01, 1'b0);
    run_op(8, 32'h7F, 32'h01, 1'b0);

    // Start pulsed mid-RUN with other operands must be ignored.
    a_in = 32'h00; b_in = 32'h00; cin = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("busy_after_accept", 64'(busy8), 64'd1);
    repeat (3) begin @(posedge clk); #1; end
    a_in = 32'h3C; b_in = 32'h5A; cin = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    ndone = 0; s_at_done = '0; c_at_done = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) begin ndone++; s_at_done = sum8; c_at_done = cout8; end
    end
    chk("ignore_start_ndone", 64'(ndone), 64'd1);
    chk("ignore_start_sum", 64'(s_at_done), 64'h01);
    chk("ignore_start_cout", 64'(c_at_done), 64'd0);

    // Start held high: back-to-back with one idle cycle.
    a_in = 32'h55; b_in = 32'hAA; cin = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    e = 0; first_e = -1; second_e = -1;
    while (e < 40 && second_e < 0) begin
      @(posedge clk); #1;
      e++;
      if (done8) begin
        if (first_e < 0) begin
          first_e = e;
          chk("held_sum", 64'(sum8), 64'hFF);
          chk("held_cout", 64'(cout8), 64'd0);
        end else begin
          second_e = e;
        end
      end
    end
    start8 = 1'b0;
    chk("held_first_done", 64'(first_e), 64'd8);
    chk("held_second_done", 64'(second_e), 64'd18);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN.
    a_in = 32'hFF; b_in = 32'hFF; cin = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy8), 64'd0);
    chk("arst_done", 64'(done8), 64'd0);
    chk("arst_sum", 64'(sum8), 64'd0);
    chk("arst_cout", 64'(cout8), 64'd0);
    #1 rst = 1'b0;
    ndone = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8) ndone++;
    end
    chk("arst_no_done", 64'(ndone), 64'd0);
    run_op(8, 32'h10, 32'h20, 1'b0);

    // Width boundaries.
    run_op(1, 32'h1, 32'h1, 1'b1);
    run_op(1, 32'h0, 32'h0, 1'b0);
    run_op(1, 32'h1, 32'h0, 1'b0);
    run_op(32, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op(32, 32'h7FFF_FFFF, 32'h0000_0000, 1'b1);
    run_op(8, 32'hFF, 32'hFF, 1'b1);
    run_op(8, 32'h80, 32'h80, 1'b0);

    for (int i = 0; i < 1000; i++) run_op(1, $urandom, $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 1000; i++) run_op(8, $urandom, $urandom, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 1000; i++) run_op(32, $urandom, $urandom, 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
